// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: in-order word fetches into a small buffer, one instruction per
// cycle to decode, with redirect flushing and discarding of stale in-flight responses.
module instr_fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] Nop = DATA_WIDTH'(32'h0000_0013);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;

  logic [DATA_WIDTH-1:0] fifo_word [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];

  logic [CW:0]           slots_used;
  logic [ADDR_WIDTH-1:0] target_pc;
  logic                  fire, rsp, push, pop;
  logic [1:0]            unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];
  assign target_pc           = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  // Buffered plus outstanding fetches are capped so the buffer can never overflow.
  assign slots_used = {1'b0, count_q} + {1'b0, outstanding_q};
  assign mem_req    = rst_n && !redirect && (slots_used < (CW+1)'(FIFO_DEPTH));
  assign mem_addr   = fetch_pc_q;

  assign fire = mem_req && mem_gnt;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp  = mem_rvalid && (outstanding_q != '0);
  assign push = rsp && (drop_cnt_q == '0) && !redirect;
  assign pop  = instr_valid && !stall && !redirect;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? fifo_word[rd_ptr_q] : Nop;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr_q] : resp_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q + CW'(fire) - CW'(rsp);

    if (redirect) begin
      // Everything still in flight becomes stale; a response arriving now is consumed here.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_cnt_d = outstanding_q - CW'(rsp);
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      end
      if (rsp && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Buffer storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_word[wr_ptr_q] <= mem_rdata;
      fifo_pc[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch front end. Produces the `instr` word consumed by the decode/control unit and honours that unit's `stall`.
- Issues in-order word fetches to instruction memory and buffers returned words in a small FIFO.
- Presents one instruction per cycle to decode.
- Handles branch/jump redirects from execute by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC and memory address width.
- FIFO_DEPTH, 4, instruction buffer entries; also the cap on buffered plus outstanding fetches (power of 2, >=2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mem_req  out  1  fetch request valid.
- mem_addr  out  ADDR_WIDTH  fetch address, word aligned.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; responses return in request order, latency >=1 cycle after grant.
- mem_rdata  in  DATA_WIDTH  returned instruction word.
- redirect  in  1  control-flow change from execute.
- redirect_pc  in  ADDR_WIDTH  new fetch target.
- stall  in  1  decode not accepting; hold outputs.
- instr  out  DATA_WIDTH  instruction to decode.
- instr_pc  out  ADDR_WIDTH  PC of `instr`.
- instr_valid  out  1  `instr` holds a real fetched instruction.

Behaviour:
- State: fetch_pc, resp_pc, FIFO of {word, pc}, count (0..FIFO_DEPTH), outstanding (0..FIFO_DEPTH), drop_cnt (0..FIFO_DEPTH). Counters are $clog2(FIFO_DEPTH)+1 bits.
- Reset (async, rst_n=0): fetch_pc=resp_pc=RESET_PC; count=outstanding=drop_cnt=0; mem_req=0; instr_valid=0; instr=32'h0000_0013 (NOP, addi x0,x0,0); instr_pc=RESET_PC. Reset asserted mid-transfer abandons all in-flight state; responses arriving after reset release are not expected.
- Issue:
  - mem_req = !redirect && (count + outstanding - drop_cnt + drop_cnt) < FIFO_DEPTH, i.e. count + outstanding < FIFO_DEPTH.
  - mem_addr = fetch_pc.
  - On mem_req && mem_gnt: fetch_pc += 4; outstanding += 1.
  - mem_req and mem_addr are stable until granted, unless a redirect occurs.
- Response: on mem_rvalid, outstanding -= 1.
  - If drop_cnt>0: drop_cnt -= 1 and the word is discarded.
  - Else: push {mem_rdata, resp_pc}; resp_pc += 4.
  - Grant and rvalid in the same cycle update outstanding by net 0.
  - mem_rvalid while outstanding==0 is a protocol violation: ignored, and flagged by a bench assertion.
- Output (combinational from the FIFO head):
  - instr_valid = count!=0.
  - instr / instr_pc = head entry when valid, else NOP / resp_pc.
  - Latency: mem_rvalid at cycle t gives instr_valid at t+1 when the FIFO was empty.
- Pop: on instr_valid && !stall. A push and a pop in the same cycle leave count unchanged. While stall=1, instr, instr_pc and instr_valid hold stable.
- Redirect (highest priority, acts even when stall=1):
  - Next cycle: count=0; fetch_pc = resp_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - drop_cnt = outstanding - (mem_rvalid ? 1 : 0). Any rvalid in the redirect cycle is discarded; prior drop_cnt is subsumed.
  - No request is issued and no push occurs in the redirect cycle.
  - First new request appears the cycle after redirect.
- Full: count + outstanding == FIFO_DEPTH gives mem_req=0 until a pop or a drop frees a slot. The FIFO can never overflow.
- Wrap-around: fetch_pc and resp_pc wrap modulo 2^ADDR_WIDTH.

Test Plan:
- Reset then zero-latency-grant memory returning mem[a]=a (1-cycle rvalid), stall=0 → mem_addr 0,4,8…; instr_valid from cycle 2; instr_pc = instr = 0,4,8… one per cycle, no gaps.
- Hold stall=1 for 10 cycles with memory always granting → FIFO fills; mem_req drops once count+outstanding=4; instr/instr_pc frozen at the same value; releasing stall resumes in order with no loss or duplication.
- Memory latency 3 cycles, redirect with redirect_pc=0x100 while 3 fetches are outstanding → those 3 responses are dropped; first instr_valid carries instr_pc=0x100; no stale PC is ever presented.
- Redirect in the same cycle as mem_rvalid with outstanding=2 → drop_cnt=1; next mem_addr=target; only one further response is discarded.
- redirect_pc=0x203 → mem_addr=0x200 and instr_pc=0x200.
- mem_gnt withheld 5 cycles → mem_req and mem_addr held at the same PC; instr_valid=0 with instr=NOP once the FIFO drains.
